uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side buffer sitting directly downstream of the UART receiver.
//   Takes each completed byte (UART rx_out/ready), performs the ready_clr
//   handshake back to the UART, and queues bytes in a circular FIFO.
//   A host drains the FIFO at its own pace, so back-to-back 115200-baud frames are not lost.
// PARAMETERS
//   WIDTH  8   data width; must match UART N
//   DEPTH  16  FIFO entries; power of two, >= 2
// PORTS
//   clk           in   1                  system clock (50 MHz)
//   reset_n       in   1                  async active-low reset
//   rx_ready      in   1                  UART ready: byte valid on rx_data
//   rx_data       in   WIDTH              UART rx_out
//   rx_ready_clr  out  1                  pulse to UART ready_clr
//   rd_en         in   1                  host pop request
//   rd_data       out  WIDTH              popped byte (registered)
//   rd_valid      out  1                  rd_data valid, 1-cycle pulse
//   empty         out  1                  count == 0
//   full          out  1                  count == DEPTH
//   count         out  $clog2(DEPTH)+1    entries stored
//   overflow      out  1                  sticky: byte dropped while full
//   ovf_clr       in   1                  clears overflow
// BEHAVIOUR
//   Reset (async, reset_n=0): pointers=0, count=0, empty=1, full=0,
//     rd_data=0, rd_valid=0, rx_ready_clr=0, overflow=0, FSM=IDLE.
//     Reset mid-frame or mid-handshake discards all contents.
//   Capture FSM (state register, 3 states):
//     IDLE: rx_ready=1 -> write rx_data (if !full) or set overflow
//           (if full); go CLR.
//     CLR:  rx_ready_clr=1 for exactly this one cycle; go WAIT.
//     WAIT: stay until rx_ready=0, then IDLE. Guarantees each UART byte
//           is written exactly once regardless of ready_clr latency.
//   Write: mem[wr_ptr]<=rx_data; wr_ptr wraps DEPTH-1 -> 0.
//   Read: rd_en=1 && !empty -> rd_data<=mem[rd_ptr], rd_valid=1 next
//     cycle (1-cycle latency); rd_ptr wraps DEPTH-1 -> 0.
//     rd_en while empty: ignored, rd_valid=0, no pointer move.
//   Simultaneous write+read same cycle: both execute, count unchanged.
//   Full + capture + rd_en same cycle: write accepted (slot freed this
//     cycle), no overflow. Full + capture, no read: byte dropped,
//     overflow=1, pointers unchanged, handshake still completed.
//   count: +1 write-only, -1 read-only, never exceeds DEPTH or < 0.
//   full/empty derived combinationally from count.
//   overflow: set has priority over ovf_clr in the same cycle.
// TESTING
//   1. Reset: reset_n=0 mid-operation -> empty=1, count=0, all outputs 0.
//   2. Single byte: drive rx_data=8'hAA, rx_ready=1 until rx_ready_clr,
//      then 0 -> count=1; rd_en 1 cycle -> rd_data=8'hAA, rd_valid=1,
//      empty=1.
//   3. Order/wrap: push 8'h00..8'h17 (24 bytes) interleaved with pops of
//      8 -> pops return 8'h00..8'h17 in order across pointer wrap.
//   4. Full/overflow: push 17 bytes 8'h01..8'h11, no reads -> full=1,
//      count=16, overflow=1, 17th (8'h11) absent; ovf_clr -> overflow=0.
//   5. Simultaneous: count=4, capture 8'hC3 with rd_en same cycle ->
//      count stays 4, popped byte is oldest, 8'hC3 last out.
//   6. Sticky ready: hold rx_ready=1 for 20 cycles after rx_ready_clr ->
//      exactly one write, single rx_ready_clr pulse.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver, the receive FIFO and the draining host.
// The slave modport is the FIFO side. The master modport is the UART/host side.
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready_clr;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             ovf_clr;

  modport slave (
    input  rx_ready, rx_data, rd_en, ovf_clr,
    output rx_ready_clr, rd_data, rd_valid, empty, full, count, overflow
  );

  modport master (
    output rx_ready, rx_data, rd_en, ovf_clr,
    input  rx_ready_clr, rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART receiver.
// It captures each ready byte once, acknowledges it with ready_clr, and lets a host pop the bytes later.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;
  logic             overflow_r;
  logic             rx_ready_clr_s;
  logic             cap_s;
  logic             full_s;
  logic             empty_s;
  logic             rd_go_s;
  logic             wr_go_s;
  logic             ovf_set_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign rd_go_s = bus.rd_en && !empty_s;
  // A pop in the same cycle frees a slot, so a capture into a full FIFO is still accepted.
  assign wr_go_s   = cap_s && (!full_s || rd_go_s);
  assign ovf_set_s = cap_s && full_s && !rd_go_s;

  // Capture FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_ready) begin
          state_nxt_s = ST_CLR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLR:  state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (!bus.rx_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Capture FSM outputs
  always_comb begin
    cap_s          = 1'b0;
    rx_ready_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: cap_s          = bus.rx_ready;
      ST_CLR:  rx_ready_clr_s = 1'b1;
      ST_WAIT: rx_ready_clr_s = 1'b0;
      default: rx_ready_clr_s = 1'b0;
    endcase
  end

  // Storage array; reset only rewinds the pointers, the old contents become unreachable
  always_ff @(posedge clk) begin
    if (wr_go_s) begin
      mem_r[wr_ptr_r] <= bus.rx_data;
    end
  end

  // Pointers, occupancy, read port and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rd_data_r  <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_go_s;
      if (wr_go_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_go_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
        rd_ptr_r  <= ptr_inc(rd_ptr_r);
      end
      case ({wr_go_s, rd_go_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign bus.rx_ready_clr = rx_ready_clr_s;
  assign bus.rd_data      = rd_data_r;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.empty        = empty_s;
  assign bus.full         = full_s;
  assign bus.count        = count_r;
  assign bus.overflow     = overflow_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a byte and hold it until the single ready_clr pulse, then release.
  task automatic push(input logic [7:0] d);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.rx_ready_clr) seen = 1'b1;
    end
    chk("push_clr_seen", 32'(seen), 32'd1);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pop(input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
  endtask

  // Capture a byte and pop in the same cycle.
  task automatic push_pop(input logic [7:0] d, input logic [7:0] exp_pop,
                          input logic [4:0] exp_cnt, input string tag);
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    bus.rd_en    = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk({tag, "_clr"}, 32'(bus.rx_ready_clr), 32'd1);
    chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.rd_data), 32'(exp_pop));
    chk({tag, "_count"}, 32'(bus.count), 32'(exp_cnt));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_b;
    int pulses;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.ovf_clr  = 1'b0;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    reset_n = 1'b1;

    // Single byte
    push(8'hAA);
    chk("t2_count", 32'(bus.count), 32'd1);
    chk("t2_empty0", 32'(bus.empty), 32'd0);
    pop(8'hAA, "t2_pop");
    chk("t2_empty1", 32'(bus.empty), 32'd1);
    @(negedge clk);
    chk("t2_valid_pulse", 32'(bus.rd_valid), 32'd0);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("t2_empty_rd", 32'(bus.rd_valid), 32'd0);
    chk("t2_empty_cnt", 32'(bus.count), 32'd0);

    // Order across pointer wrap
    exp_b = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) push(8'(r * 8 + i));
      chk("t3_count", 32'(bus.count), 32'd8);
      for (int i = 0; i < 8; i++) begin
        pop(8'(exp_b), "t3_pop");
        exp_b++;
      end
    end
    chk("t3_empty", 32'(bus.empty), 32'd1);

    // Full and overflow
    for (int i = 1; i <= 17; i++) push(8'(i));
    chk("t4_full", 32'(bus.full), 32'd1);
    chk("t4_count", 32'(bus.count), 32'd16);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(bus.overflow), 32'd0);
    push(8'h12);
    chk("t4_ovf_again", 32'(bus.overflow), 32'd1);
    chk("t4_count2", 32'(bus.count), 32'd16);
    for (int i = 1; i <= 16; i++) pop(8'(i), "t4_drain");
    chk("t4_drained", 32'(bus.empty), 32'd1);
    chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset in the middle of a handshake and a read
    push(8'h31);
    push(8'h32);
    push(8'h33);
    @(negedge clk);
    bus.rx_data  = 8'h77;
    bus.rx_ready = 1'b1;
    bus.rd_en    = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_count", 32'(bus.count), 32'd0);
    chk("t1_full", 32'(bus.full), 32'd0);
    chk("t1_rd_data", 32'(bus.rd_data), 32'd0);
    chk("t1_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("t1_clr", 32'(bus.rx_ready_clr), 32'd0);
    chk("t1_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    bus.rx_ready = 1'b0;
    bus.rd_en    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Simultaneous capture and pop at count 4
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
    push_pop(8'hC3, 8'h50, 5'd4, "t5");
    pop(8'h51, "t5_p1");
    pop(8'h52, "t5_p2");
    pop(8'h53, "t5_p3");
    pop(8'hC3, "t5_p4");
    chk("t5_empty", 32'(bus.empty), 32'd1);

    // Full, with a capture and a pop in the same cycle
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    chk("t5b_full", 32'(bus.full), 32'd1);
    push_pop(8'hE7, 8'h60, 5'd16, "t5b");
    for (int i = 1; i < 16; i++) pop(8'(8'h60 + i), "t5b_drain");
    pop(8'hE7, "t5b_last");
    chk("t5b_empty", 32'(bus.empty), 32'd1);

    // rx_ready held high long after the acknowledge
    @(negedge clk);
    bus.rx_data  = 8'h5A;
    bus.rx_ready = 1'b1;
    pulses = 0;
    repeat (22) begin
      @(negedge clk);
      if (bus.rx_ready_clr) pulses++;
    end
    bus.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_pulses", 32'(pulses), 32'd1);
    chk("t6_count", 32'(bus.count), 32'd1);
    pop(8'h5A, "t6_pop");
    chk("t6_empty", 32'(bus.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
